// File: rtl/dispatch_lane_reconfig_ctrl.sv
// Run-time dispatch-lane mask reconfiguration sequencer: stall rename, drain,
// switch the lane mask, let the lanes settle, flush once, then release.
module dispatch_lane_reconfig_ctrl #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reconfigReq_i,
  input  logic [DISPATCH_WIDTH-1:0] newLaneMask_i,
  input  logic                      backendStall_i,
  input  logic                      flush_i,
  input  logic                      pipeEmpty_i,
  output logic [DISPATCH_WIDTH-1:0] laneActive_o,
  output logic                      renStall_o,
  output logic                      renFlush_o,
  output logic                      reconfigBusy_o,
  output logic                      reconfigDone_o,
  output logic                      reconfigErr_o
);

  // state   | meaning
  // IDLE    | normal operation, requests accepted
  // DRAIN   | rename stalled, waiting for the pipeline to empty
  // GATE    | one cycle, new lane mask and settle count loaded at its end
  // SETTLE  | waiting SETTLE_CYCLES for the lane power to settle
  // FLUSH   | one-cycle flush of the rename/dispatch register, done pulse
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam logic [7:0]                SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [DISPATCH_WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [DISPATCH_WIDTH-1:0] ONE         = DISPATCH_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [DISPATCH_WIDTH-1:0] lane_active_q, lane_active_d;
  logic [DISPATCH_WIDTH-1:0] pending_mask_q, pending_mask_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      same_done_q, same_done_d;

  // A legal mask is a non-empty run of ones anchored at lane 0, i.e. m+1 is a power of two.
  function automatic logic mask_legal(input logic [DISPATCH_WIDTH-1:0] m);
    logic [DISPATCH_WIDTH-1:0] m_inc;
    m_inc = m + ONE;
    return (m != '0) && ((m & m_inc) == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lane_active_q  <= ALL_ONES;
      pending_mask_q <= ALL_ONES;
      cnt_q          <= 8'd0;
      err_q          <= 1'b0;
      same_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_active_q  <= lane_active_d;
      pending_mask_q <= pending_mask_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      same_done_q    <= same_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lane_active_d  = lane_active_q;
    pending_mask_d = pending_mask_q;
    cnt_d          = cnt_q;
    err_d          = 1'b0;
    same_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reconfigReq_i) begin
          if (!mask_legal(newLaneMask_i)) begin
            err_d = 1'b1;
          end else if (newLaneMask_i == lane_active_q) begin
            same_done_d = 1'b1;
          end else begin
            pending_mask_d = newLaneMask_i;
            state_d        = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pipeEmpty_i) state_d = S_GATE;
      end
      S_GATE: begin
        lane_active_d = pending_mask_q;
        cnt_d         = SETTLE_INIT;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Busy/stall and flush merge are combinational so backend controls pass through with no lag.
  assign laneActive_o   = lane_active_q;
  assign reconfigBusy_o = (state_q != S_IDLE);
  assign renStall_o     = backendStall_i | (state_q != S_IDLE);
  assign renFlush_o     = flush_i | (state_q == S_FLUSH);
  assign reconfigDone_o = same_done_q | (state_q == S_FLUSH);
  assign reconfigErr_o  = err_q;

endmodule

// File: tb/tb_dispatch_lane_reconfig_ctrl.sv
// Bench for dispatch_lane_reconfig_ctrl: constant vector table, corner-case
// sequences and random traffic checked against a cycle-count reference model.
module tb_dispatch_lane_reconfig_ctrl;
  localparam int W = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset, req, bst, fl, pe;
  logic [W-1:0] mask;
  logic [W-1:0] lane;
  logic         stall, rflush, busy, done, err;

  int n_checks = 0;
  int n_err    = 0;

  dispatch_lane_reconfig_ctrl #(.DISPATCH_WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .reconfigReq_i(req), .newLaneMask_i(mask),
    .backendStall_i(bst), .flush_i(fl), .pipeEmpty_i(pe),
    .laneActive_o(lane), .renStall_o(stall), .renFlush_o(rflush),
    .reconfigBusy_o(busy), .reconfigDone_o(done), .reconfigErr_o(err)
  );

  always #5 clk = ~clk;

  // Reference model: "drain" flag, then a countdown of S+2 cycles covering
  // GATE, S settle cycles and the flush cycle (left==1).
  logic         m_valid = 1'b0;
  logic [W-1:0] m_lane, m_pend;
  logic         m_drain, m_err, m_done;
  int           m_left;

  logic [8:0] o_vec;   // {lane, stall, rflush, busy, done, err} seen this cycle

  function automatic logic legal(input logic [W-1:0] m);
    for (int k = 1; k <= W; k++)
      if (int'(m) == (1 << k) - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_out(input logic b, input logic f);
    logic mbusy;
    mbusy = m_drain || (m_left > 0);
    return {m_lane, b | mbusy, f | (m_left == 1), mbusy, m_done | (m_left == 1), m_err};
  endfunction

  task automatic cyc(input logic r, input logic q, input logic [W-1:0] m,
                     input logic b, input logic f, input logic p);
    logic nerr, ndone;
    @(negedge clk);
    reset = r; req = q; mask = m; bst = b; fl = f; pe = p;
    #1;
    o_vec = {lane, stall, rflush, busy, done, err};
    if (m_valid && !r) chk("model", 32'(o_vec), 32'(model_out(b, f)));
    if (m_valid && !r) chk("done_err_excl", 32'(done & err), 32'd0);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b1; m_lane = '1; m_pend = '1;
      m_drain = 1'b0; m_left = 0; m_err = 1'b0; m_done = 1'b0;
    end else if (m_valid) begin
      nerr = 1'b0; ndone = 1'b0;
      if (!m_drain && m_left == 0) begin
        if (q) begin
          if (!legal(m)) nerr = 1'b1;
          else if (m == m_lane) ndone = 1'b1;
          else begin m_pend = m; m_drain = 1'b1; end
        end
      end else if (m_drain) begin
        if (p) begin m_drain = 1'b0; m_left = S + 2; end
      end else begin
        if (m_left == S + 2) m_lane = m_pend;
        m_left--;
      end
      m_err = nerr; m_done = ndone;
    end
  endtask

  typedef struct {
    logic [8:0] in;    // {rst, req, mask[3:0], bst, fl, pe}
    logic [8:0] exp;   // {lane[3:0], stall, rflush, busy, done, err}
    logic       chk;
  } vec_t;

  vec_t tbl[19];

  initial begin
    reset = 1'b1; req = 1'b0; mask = '0; bst = 1'b0; fl = 1'b0; pe = 1'b0;

    tbl[0]  = '{9'b1_0_0000_0_0_0, 9'b1111_0_0_0_0_0, 1'b0};
    tbl[1]  = '{9'b0_0_0000_0_0_0, 9'b1111_0_0_0_0_0, 1'b1};
    tbl[2]  = '{9'b0_0_0000_1_0_0, 9'b1111_1_0_0_0_0, 1'b1};
    tbl[3]  = '{9'b0_1_0011_0_0_1, 9'b1111_0_0_0_0_0, 1'b1};
    tbl[4]  = '{9'b0_0_0000_0_0_1, 9'b1111_1_0_1_0_0, 1'b1};
    tbl[5]  = '{9'b0_0_0000_0_0_1, 9'b1111_1_0_1_0_0, 1'b1};
    tbl[6]  = '{9'b0_0_0000_0_0_1, 9'b0011_1_0_1_0_0, 1'b1};
    tbl[7]  = '{9'b0_0_0000_0_0_1, 9'b0011_1_0_1_0_0, 1'b1};
    tbl[8]  = '{9'b0_0_0000_0_0_1, 9'b0011_1_0_1_0_0, 1'b1};
    tbl[9]  = '{9'b0_0_0000_0_0_1, 9'b0011_1_0_1_0_0, 1'b1};
    tbl[10] = '{9'b0_0_0000_0_0_1, 9'b0011_1_1_1_1_0, 1'b1};
    tbl[11] = '{9'b0_0_0000_0_0_1, 9'b0011_0_0_0_0_0, 1'b1};
    tbl[12] = '{9'b0_1_0101_0_0_1, 9'b0011_0_0_0_0_0, 1'b1};
    tbl[13] = '{9'b0_0_0000_0_0_1, 9'b0011_0_0_0_0_1, 1'b1};
    tbl[14] = '{9'b0_1_0000_0_0_1, 9'b0011_0_0_0_0_0, 1'b1};
    tbl[15] = '{9'b0_0_0000_0_0_1, 9'b0011_0_0_0_0_1, 1'b1};
    tbl[16] = '{9'b0_1_0011_0_0_1, 9'b0011_0_0_0_0_0, 1'b1};
    tbl[17] = '{9'b0_0_0000_0_0_1, 9'b0011_0_0_0_1_0, 1'b1};
    tbl[18] = '{9'b0_0_0000_0_1_1, 9'b0011_0_1_0_0_0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].in[8], tbl[i].in[7], tbl[i].in[6:3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), 32'(o_vec), 32'(tbl[i].exp));
    end

    // Illegal 1110 and same-mask 1111 from reset: pulses only, never busy.
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("err_1110", 32'({err, done, busy, lane}), 32'({1'b1, 1'b0, 1'b0, 4'hF}));
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("same_1111", 32'({err, done, busy, lane}), 32'({1'b0, 1'b1, 1'b0, 4'hF}));

    // Drain held for 10 cycles, then pipeEmpty rises.
    cyc(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("drain_hold", 32'({busy, stall, lane}), 32'({1'b1, 1'b1, 4'hF}));
    end
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_exit", 32'({busy, lane}), 32'({1'b1, 4'hF}));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("gate_lane", 32'(lane), 32'h0F);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("new_lane", 32'(lane), 32'h07);
    for (int i = 0; i < S + 2; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_idle", 32'({busy, lane}), 32'({1'b0, 4'h7}));

    // Flush during DRAIN passes through; request during SETTLE is ignored.
    cyc(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("flush_in_drain", 32'({rflush, busy}), 32'({1'b1, 1'b1}));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < S + 4; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("req_ignored", 32'({busy, lane}), 32'({1'b0, 4'h3}));

    // Reset in SETTLE after switching to 0001.
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("settle_lane", 32'({busy, lane}), 32'({1'b1, 4'h1}));
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_abort", 32'({lane, busy, done, err, rflush}), 32'({4'hF, 4'b0000}));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] rm;
      if ($urandom_range(0, 1) == 0) rm = W'((1 << $urandom_range(1, W)) - 1);
      else rm = W'($urandom_range(0, (1 << W) - 1));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), rm,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dispatch_lane_reconfig_ctrl.md
Name: dispatch_lane_reconfig_ctrl

Overview:
Sequences run-time changes of the active dispatch-lane mask for the rename/dispatch pipeline register and the backend. It takes a reconfiguration request, stalls rename, waits for the pipeline to drain, and switches the lane mask. It then waits a fixed power-settle interval and issues a one-cycle flush before releasing the stall. In normal operation it merges the backend stall and recovery flush into the rename-stage stall and flush controls.

Parameters:
DISPATCH_WIDTH, 4, number of dispatch lanes (width of lane mask)
SETTLE_CYCLES, 4, cycles held in SETTLE after the mask change; legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
reconfigReq_i  in  1  request to apply newLaneMask_i; sampled only in IDLE
newLaneMask_i  in  DISPATCH_WIDTH  requested lane mask
backendStall_i  in  1  stall from the backend
flush_i  in  1  recovery flush from the backend
pipeEmpty_i  in  1  high when no instructions are in flight from rename to issue
laneActive_o  out  DISPATCH_WIDTH  current active-lane mask (registered)
renStall_o  out  1  stall to the rename/dispatch register
renFlush_o  out  1  flush to the rename/dispatch register
reconfigBusy_o  out  1  high in any state other than IDLE
reconfigDone_o  out  1  one-cycle pulse when a reconfiguration completes
reconfigErr_o  out  1  one-cycle pulse when a request is rejected (registered)

Behaviour:
- Reset values:
  - laneActive_o = all ones; state = IDLE; pendingMask = all ones; counter = 0.
  - reconfigErr_o = 0.
  - Combinational outputs follow from IDLE state and the current inputs.
- Reset asserted mid-sequence aborts the sequence immediately and returns to the reset values. No done or error pulse is generated.
- Legal mask: contiguous ones starting at lane 0 (0001, 0011, 0111, 1111 for width 4). All other values, including zero, are illegal.
- States: IDLE, DRAIN, GATE, SETTLE, FLUSH.
- IDLE, on reconfigReq_i = 1:
  - Illegal mask: reconfigErr_o = 1 in the next cycle; state and mask are unchanged.
  - Legal mask equal to laneActive_o: reconfigDone_o = 1 in the next cycle; state stays IDLE.
  - Legal mask that differs: capture it into pendingMask and go to DRAIN next cycle.
- reconfigReq_i is ignored in every state other than IDLE and is not queued.
- DRAIN: renStall_o forced to 1. When pipeEmpty_i = 1 in a DRAIN cycle, go to GATE next cycle. There is no timeout.
- GATE: lasts one cycle. laneActive_o is loaded with pendingMask at the end of this cycle, and the counter is loaded with SETTLE_CYCLES. Next state is SETTLE.
- SETTLE: the counter decrements each cycle. When counter = 1, go to FLUSH next cycle. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- FLUSH: lasts one cycle. renFlush_o = 1 and reconfigDone_o = 1. Next state is IDLE.
- renStall_o = backendStall_i OR (state != IDLE).
- renFlush_o = flush_i OR (state == FLUSH).
  - flush_i passes through in all states and never aborts the sequence.
- reconfigBusy_o = (state != IDLE).
- Latency, with the request in cycle 0 and pipeEmpty_i already high:
  - DRAIN in cycle 1, GATE in cycle 2.
  - New laneActive_o visible from cycle 3.
  - FLUSH in cycle 3+SETTLE_CYCLES; IDLE in cycle 4+SETTLE_CYCLES.
- Simultaneous reconfigReq_i and flush_i in IDLE: both take effect. The flush passes through and the request is accepted.
- reconfigDone_o and reconfigErr_o are never high in the same cycle.

Test Plan:
- Reset -> laneActive_o = 1111, all other outputs 0. With backendStall_i = 1, renStall_o = 1 in the same cycle.
- Request 0011 at cycle 0 with pipeEmpty_i = 1 and SETTLE_CYCLES = 4 -> DRAIN in cycle 1, GATE in cycle 2, laneActive_o = 0011 from cycle 3. renFlush_o and reconfigDone_o are high only in cycle 7. reconfigBusy_o is high in cycles 1-7 and renStall_o in cycles 1-7; IDLE in cycle 8.
- Request 0111 with pipeEmpty_i low for 10 cycles -> remains in DRAIN with renStall_o = 1 and laneActive_o unchanged. Advances to GATE one cycle after pipeEmpty_i rises.
- Requests with masks 0101, 0000 and 1110 -> reconfigErr_o pulses 1 cycle after each request; laneActive_o stays 1111 and busy never asserts. A request for 1111 while at 1111 -> reconfigDone_o pulse only.
- Second request issued during SETTLE, and flush_i pulsed during DRAIN -> second request ignored. renFlush_o follows flush_i and the sequence completes normally.
- Reset asserted during SETTLE after the mask changed to 0001 -> next cycle IDLE with laneActive_o = 1111 and no done pulse.
